// File: rtl/wt_dcache_mem_responder_pkg.sv
// Purpose: shared types and constants for the dcache memory-side responder.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package wt_dcache_mem_responder_pkg;

  // Widths baked into the response record; the top-level parameters default to these.
  localparam int RSP_LINE_WIDTH = 128;
  localparam int RSP_TID_WIDTH  = 2;
  localparam int DFLT_MEM_LINES = 1024;

  // Byte offset inside a 128-bit line, and the line-index width for the default SRAM depth.
  localparam int OFF_WIDTH = 4;
  localparam int IDX_WIDTH = $clog2(DFLT_MEM_LINES);

  typedef struct packed {
    logic                      store;
    logic [RSP_LINE_WIDTH-1:0] data;
    logic [RSP_TID_WIDTH-1:0]  tid;
    logic                      err;
  } rsp_t;

endpackage

// File: rtl/wt_dcache_mem_responder_rsp_fifo.sv
// Purpose: first-word-fall-through FIFO of response records with full/empty flags.
// Latency: a pushed entry becomes visible on pop_dat_o the cycle after the push.
// Backpressure: push while full is dropped unless a pop frees the slot in the same cycle.
//
// Ports: clk_i/rst_i clock and async active-high reset; push_i/push_dat_i write side;
//        pop_i/pop_dat_o read side (head always presented); full_o/empty_o status.
module wt_rsp_fifo
  import wt_dcache_mem_responder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  rsp_t push_dat_i,
  input  logic pop_i,
  output rsp_t pop_dat_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  rsp_t        r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_push;
  logic        w_pop;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // When full, a simultaneous pop frees the very slot being written.
  assign w_push = push_i && (!full_o || pop_i);
  assign w_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= push_dat_i;
  end

  assign pop_dat_o = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/wt_dcache_mem_responder.sv
// Purpose: memory-side responder for the write-through dcache; services loads/stores from a line SRAM.
// Latency: response visible LATENCY+1 cycles after acceptance when the response FIFO is empty.
// Backpressure: req_ready_o drops once RSP_DEPTH responses are outstanding; rsp_* held while !rsp_ready_i.
//
// Ports: clk_i/rst_i clock and async active-high reset;
//        req_* request channel (valid/ready, store flag, byte address, store data + byte enables, TID);
//        rsp_* response channel (valid/ready, store-ack flag, line data, echoed TID, out-of-range error).
module wt_dcache_mem_responder
  import wt_dcache_mem_responder_pkg::*;
#(
  parameter int LINE_WIDTH = RSP_LINE_WIDTH,
  parameter int DATA_WIDTH = 64,
  parameter int TID_WIDTH  = RSP_TID_WIDTH,
  parameter int ADDR_WIDTH = 64,
  parameter int MEM_LINES  = DFLT_MEM_LINES,
  parameter int LATENCY    = 2,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_store_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_be_i,
  input  logic [TID_WIDTH-1:0]    req_tid_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic                    rsp_store_o,
  output logic [LINE_WIDTH-1:0]   rsp_data_o,
  output logic [TID_WIDTH-1:0]    rsp_tid_o,
  output logic                    rsp_err_o
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

  logic [LINE_WIDTH-1:0] r_mem [MEM_LINES];
  logic [CNT_W-1:0]      r_count;
  rsp_t                  r_pipe [LATENCY];
  logic [LATENCY-1:0]    r_pipe_vld;

  logic             w_acc;
  logic             w_fire;
  logic [IDX_W-1:0] w_idx;
  logic             w_word;
  logic             w_oor;
  rsp_t             w_new;
  rsp_t             w_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_unused;

  // Ready depends only on the outstanding count, so there is no valid->ready path.
  assign req_ready_o = (r_count < CNT_W'(RSP_DEPTH));
  assign w_acc       = req_valid_i && req_ready_o;
  assign w_fire      = rsp_valid_o && rsp_ready_i;

  assign w_idx  = req_addr_i[OFF_WIDTH +: IDX_W];
  assign w_word = req_addr_i[3];
  assign w_oor  = |req_addr_i[ADDR_WIDTH-1:OFF_WIDTH+IDX_W];

  // Byte offset within the word and the full-flag are intentionally ignored.
  assign w_unused = ^{req_addr_i[2:0], w_fifo_full};

  // Store write happens at acceptance so a load accepted the next cycle already sees it.
  always_ff @(posedge clk_i) begin
    if (w_acc && req_store_i && !w_oor) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (req_be_i[b]) r_mem[w_idx][int'(w_word)*DATA_WIDTH + b*8 +: 8] <= req_wdata_i[b*8 +: 8];
      end
    end
  end

  always_comb begin
    w_new       = '0;
    w_new.store = req_store_i;
    w_new.tid   = req_tid_i;
    w_new.err   = w_oor;
    if (!req_store_i && !w_oor) w_new.data = r_mem[w_idx];
  end

  // Fixed-latency delay line; the count bound guarantees the FIFO has room at the end of it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pipe_vld <= '0;
    end else begin
      r_pipe_vld[0] <= w_acc;
      for (int i = 1; i < LATENCY; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    r_pipe[0] <= w_new;
    for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else begin
      case ({w_acc, w_fire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  wt_rsp_fifo #(
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (r_pipe_vld[LATENCY-1]),
    .push_dat_i (r_pipe[LATENCY-1]),
    .pop_i      (w_fire),
    .pop_dat_o  (w_head),
    .full_o     (w_fifo_full),
    .empty_o    (w_fifo_empty)
  );

  // Fields read as zero whenever no response is presented (FIFO storage itself is not reset).
  assign rsp_valid_o = !w_fifo_empty;
  assign rsp_store_o = w_fifo_empty ? 1'b0 : w_head.store;
  assign rsp_data_o  = w_fifo_empty ? '0   : w_head.data;
  assign rsp_tid_o   = w_fifo_empty ? '0   : w_head.tid;
  assign rsp_err_o   = w_fifo_empty ? 1'b0 : w_head.err;

endmodule

// File: tb/tb_wt_dcache_mem_responder.sv
module tb_wt_dcache_mem_responder;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         req_valid_i;
  logic         req_ready_o;
  logic         req_store_i;
  logic [63:0]  req_addr_i;
  logic [63:0]  req_wdata_i;
  logic [7:0]   req_be_i;
  logic [1:0]   req_tid_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic         rsp_store_o;
  logic [127:0] rsp_data_o;
  logic [1:0]   rsp_tid_o;
  logic         rsp_err_o;

  wt_dcache_mem_responder dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_store_i (req_store_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_be_i    (req_be_i),
    .req_tid_i   (req_tid_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_store_o (rsp_store_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_tid_o   (rsp_tid_o),
    .rsp_err_o   (rsp_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         store;
    logic [127:0] data;
    logic [127:0] mask;   // bits of data that are defined (SRAM is never reset)
    logic [1:0]   tid;
    logic         err;
  } exp_t;

  exp_t         sbq[$];
  logic [127:0] m_data  [1024];
  logic [127:0] m_known [1024];
  int           n_cmp = 0;
  int           n_err = 0;
  bit           rand_rdy = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: memory as an array of lines, updated byte by byte in acceptance order.
  function automatic exp_t model(input logic st, input logic [63:0] a, input logic [63:0] wd,
                                 input logic [7:0] be, input logic [1:0] tid);
    exp_t e;
    int   idx;
    int   pos;
    logic oor;
    oor     = (a >= 64'd16384);               // 1024 lines * 16 bytes
    idx     = int'((a / 64'd16) % 64'd1024);
    e.store = st;
    e.tid   = tid;
    e.err   = oor;
    e.data  = '0;
    e.mask  = '1;
    if (st) begin
      if (!oor) begin
        for (int b = 0; b < 8; b++) begin
          if (be[b]) begin
            pos = (int'((a / 64'd8) % 64'd2) * 8 + b) * 8;
            m_data[idx][pos +: 8]  = wd[b*8 +: 8];
            m_known[idx][pos +: 8] = 8'hFF;
          end
        end
      end
    end else if (!oor) begin
      e.data = m_data[idx];
      e.mask = m_known[idx];
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) rsp_ready_i = (($urandom % 4) != 0);
  endtask

  task automatic issue(input logic st, input logic [63:0] a, input logic [63:0] wd,
                       input logic [7:0] be, input logic [1:0] tid);
    bit done = 0;
    req_valid_i = 1'b1;
    req_store_i = st;
    req_addr_i  = a;
    req_wdata_i = wd;
    req_be_i    = be;
    req_tid_i   = tid;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (req_ready_o) begin
        sbq.push_back(model(st, a, wd, be, tid));
        done = 1;
      end
      step();
    end
    req_valid_i = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: req_ready_o stayed %0b, expected 1", req_ready_o);
    end
  endtask

  task automatic drain();
    int k = 0;
    rand_rdy    = 0;
    rsp_ready_i = 1'b1;
    while ((sbq.size() != 0 || rsp_valid_o) && k < 1000) begin
      step();
      k++;
    end
    chk("drain_left", 128'(sbq.size()), 128'd0);
  endtask

  // Monitor: every response handshake is compared against the head of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_i && rsp_valid_o && rsp_ready_i) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rsp: tid %0d arrived, expected no response", rsp_tid_o);
      end else begin
        e = sbq.pop_front();
        chk("rsp_store", 128'(rsp_store_o), 128'(e.store));
        chk("rsp_tid",   128'(rsp_tid_o),   128'(e.tid));
        chk("rsp_err",   128'(rsp_err_o),   128'(e.err));
        chk("rsp_data",  rsp_data_o & e.mask, e.data & e.mask);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int lat;
    int acc;
    int vcnt;
    bit seen;
    logic [63:0] a;

    for (int i = 0; i < 1024; i++) begin
      m_data[i]  = '0;
      m_known[i] = '0;
    end
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_store_i = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_be_i    = '0;
    req_tid_i   = '0;
    rsp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_i = 1'b0;

    @(negedge clk);
    chk("rst_rsp_valid", 128'(rsp_valid_o), 128'd0);
    chk("rst_rsp_store", 128'(rsp_store_o), 128'd0);
    chk("rst_rsp_data",  rsp_data_o,        128'd0);
    chk("rst_rsp_tid",   128'(rsp_tid_o),   128'd0);
    chk("rst_rsp_err",   128'(rsp_err_o),   128'd0);
    chk("rst_req_ready", 128'(req_ready_o), 128'd1);
    step();

    // First store and its latency from acceptance to visibility.
    issue(1'b1, 64'h20, 64'h1122334455667788, 8'hFF, 2'd1);
    lat  = 0;
    seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        lat  = k;
        seen = 1;
      end
    end
    chk("store_latency", 128'(lat), 128'd3);

    step();
    issue(1'b0, 64'h28, 64'h0, 8'h00, 2'd2);
    issue(1'b1, 64'h20, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 2'd3);
    issue(1'b0, 64'h20, 64'h0, 8'h00, 2'd0);
    issue(1'b1, 64'h28, 64'h5555, 8'h00, 2'd1);      // be=0: acked, nothing written
    issue(1'b0, 64'h20, 64'h0, 8'h00, 2'd2);
    drain();

    // Fill the credit window with responses blocked.
    rsp_ready_i = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid_i = 1'b1;
      req_store_i = 1'b1;
      req_addr_i  = 64'h40 + 64'(i) * 64'h10;
      req_wdata_i = {$urandom, $urandom};
      req_be_i    = 8'hFF;
      req_tid_i   = 2'(i);
      @(negedge clk);
      if (req_ready_o) begin
        acc++;
        sbq.push_back(model(1'b1, req_addr_i, req_wdata_i, req_be_i, req_tid_i));
      end
      step();
    end
    req_valid_i = 1'b0;
    chk("burst_accepted", 128'(acc), 128'd4);
    @(negedge clk);
    chk("burst_ready_low", 128'(req_ready_o), 128'd0);
    step();
    step();
    rsp_ready_i = 1'b1;
    vcnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid_o) vcnt++;
    end
    chk("burst_back_to_back", 128'(vcnt), 128'd4);
    @(negedge clk);
    chk("burst_ready_back", 128'(req_ready_o), 128'd1);
    chk("burst_empty", 128'(rsp_valid_o), 128'd0);
    step();

    // Out-of-range store must not alias onto its line index.
    issue(1'b1, 64'h30, 64'h0123456789ABCDEF, 8'hFF, 2'd0);
    issue(1'b1, 64'h38, 64'hFEDCBA9876543210, 8'hFF, 2'd1);
    issue(1'b1, (64'd1 << 40) | 64'h30, 64'hDEADBEEFDEADBEEF, 8'hFF, 2'd2);
    issue(1'b0, (64'd1 << 40) | 64'h30, 64'h0, 8'h00, 2'd3);
    issue(1'b0, 64'h30, 64'h0, 8'h00, 2'd0);
    drain();

    // Randomised traffic with random response backpressure.
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      if (($urandom % 4) == 0) begin
        step();
      end else begin
        a = (64'($urandom % 16) << 4) | 64'($urandom % 16);
        if (($urandom % 16) == 0) a = a | (64'd1 << (14 + $urandom_range(49, 0)));
        issue(1'($urandom), a, {$urandom, $urandom}, 8'($urandom), 2'($urandom));
      end
    end
    drain();

    // Reset with requests in flight.
    rsp_ready_i = 1'b0;
    issue(1'b0, 64'h20, 64'h0, 8'h00, 2'd1);
    issue(1'b0, 64'h30, 64'h0, 8'h00, 2'd2);
    issue(1'b1, 64'h50, 64'h77, 8'h01, 2'd3);
    @(negedge clk);
    chk("pre_reset_valid", 128'(rsp_valid_o), 128'd1);
    step();
    #3;
    rst_i = 1'b1;
    sbq.delete();
    #1;
    chk("async_reset_valid", 128'(rsp_valid_o), 128'd0);
    chk("async_reset_tid",   128'(rsp_tid_o),   128'd0);
    @(posedge clk);
    #2 rst_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", 128'(req_ready_o), 128'd1);
    vcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid_o) vcnt++;
    end
    chk("post_reset_no_stale", 128'(vcnt), 128'd0);

    // Memory survives reset.
    step();
    issue(1'b0, 64'h30, 64'h0, 8'h00, 2'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
